fetch_unit: RTL

//  Instruction fetch stage. Sits upstream of the L1 cache, on its processor-side sysbus port.

---
 rtl/sysbus_pkg.sv | 8 +
 rtl/fetch_line_buffer.sv | 18 +
 rtl/fetch_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/sysbus_pkg.sv
// sysbus_pkg: sysbus tag encodings, line geometry and fetch FSM states shared by the fetch unit.
package sysbus_pkg;
    localparam logic        SYSBUS_READ     = 1'b1;
    localparam logic        SYSBUS_WRITE    = 1'b0;
    localparam logic [12:0] SYSBUS_INSTR_RD = {SYSBUS_READ, 12'h000};
    localparam int          LINE_BITS       = 512;
    typedef enum logic [2:0] {IDLE, REQ, RECV, DELIVER, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer: one 64-byte cache line, written a 64-bit beat at a time, read a 32-bit word at a time.
module fetch_line_buffer
    import sysbus_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [2:0]  widx,
    input  logic [63:0] wdata,
    input  logic [3:0]  ridx,
    output logic [31:0] rdata
);
    logic [LINE_BITS-1:0] line;

    always_ff @(posedge clk)
        if (we) line[{widx, 6'b0} +: 64] <= wdata;

    assign rdata = line[{ridx, 5'b0} +: 32];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetches 64-byte lines over sysbus and streams 32-bit instructions with their PCs to decode.
module fetch_unit
    import sysbus_pkg::*;
#(
    parameter int                BUS_DATA_WIDTH = 64,
    parameter int                BUS_TAG_WIDTH  = 13,
    parameter int                LINE_BEATS     = 8,
    parameter int                INSTR_WIDTH    = 32,
    parameter logic [63:0]       RESET_PC       = 64'h0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      redirect,
    input  logic [BUS_DATA_WIDTH-1:0] redirect_pc,
    output logic                      bus_reqcyc,
    input  logic                      bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [INSTR_WIDTH-1:0]    instr,
    output logic [BUS_DATA_WIDTH-1:0] instr_pc
);
    localparam int LW = BUS_DATA_WIDTH - 6;

    fetch_state_t              state;
    logic [BUS_DATA_WIDTH-1:0] pc, pc_nxt;
    logic [LW-1:0]             req_line, line_addr;
    logic [2:0]                beat_cnt;
    logic                      line_valid, redirect_pend, fire, last_beat, unused_ok;
    logic [INSTR_WIDTH-1:0]    rd_instr;

    fetch_line_buffer u_buf (
        .clk   (clk),
        .we    (state == RECV && bus_respack),
        .widx  (beat_cnt),
        .wdata (bus_resp),
        .ridx  (pc[5:2]),
        .rdata (rd_instr)
    );

    assign bus_reqcyc  = state == REQ;
    assign bus_req     = bus_reqcyc ? {req_line, 6'b0} : '0;
    assign bus_reqtag  = bus_reqcyc ? SYSBUS_INSTR_RD : '0;
    assign bus_respack = bus_respcyc && (state == RECV || state == DRAIN);
    assign instr_valid = state == DELIVER && line_valid && pc[BUS_DATA_WIDTH-1:6] == line_addr;
    assign instr       = instr_valid ? rd_instr : '0;
    assign instr_pc    = pc;
    // a redirect voids any handshake in the same cycle
    assign fire        = instr_valid && instr_ready && !redirect;
    assign last_beat   = bus_respack && beat_cnt == 3'(LINE_BEATS - 1);
    assign pc_nxt      = redirect ? {redirect_pc[BUS_DATA_WIDTH-1:2], 2'b0} : fire ? pc + 4 : pc;
    assign unused_ok   = ^{bus_resptag, redirect_pc[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            line_valid    <= 1'b0;
            beat_cnt      <= '0;
            redirect_pend <= 1'b0;
            req_line      <= '0;
            line_addr     <= '0;
        end else begin
            pc <= pc_nxt;
            if (bus_respack) beat_cnt <= beat_cnt + 3'd1;
            case (state)
                IDLE: begin
                    state    <= REQ;
                    req_line <= pc_nxt[BUS_DATA_WIDTH-1:6];
                end
                // address stays frozen until ack; a redirect here only marks the line as stale
                REQ: begin
                    if (bus_reqack) begin
                        state         <= (redirect_pend || redirect) ? DRAIN : RECV;
                        redirect_pend <= 1'b0;
                        line_valid    <= 1'b0;
                        beat_cnt      <= '0;
                    end else if (redirect) begin
                        redirect_pend <= 1'b1;
                    end
                end
                RECV: begin
                    if (last_beat) begin
                        line_valid <= 1'b1;
                        line_addr  <= req_line;
                        state      <= pc_nxt[BUS_DATA_WIDTH-1:6] == req_line ? DELIVER : REQ;
                        req_line   <= pc_nxt[BUS_DATA_WIDTH-1:6];
                    end else if (redirect) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_beat) begin
                        state    <= REQ;
                        req_line <= pc_nxt[BUS_DATA_WIDTH-1:6];
                    end
                end
                DELIVER: begin
                    if (redirect ? !(line_valid && pc_nxt[BUS_DATA_WIDTH-1:6] == line_addr)
                                 : fire && pc[5:2] == 4'hf) begin
                        state    <= REQ;
                        req_line <= pc_nxt[BUS_DATA_WIDTH-1:6];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
